// File: rtl/gpio_audio_dac_tx.sv
// Serial DAC transmitter: one MSB-first cs_n/sclk/mosi frame per accepted PCM sample.
// Define MUSICBOX_DAC_TX_STATS_EN to add the frame_count output.
module gpio_audio_dac_tx #(
    parameter int DATA_WIDTH = 16,
    parameter int CLK_DIV    = 4,
    parameter int FRAME_GAP  = 2
) (
    input  logic                  max10Board_50MhzClock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] sample_data,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  dac_cs_n,
    output logic                  dac_sclk,
    output logic                  dac_mosi
`ifdef MUSICBOX_DAC_TX_STATS_EN
    ,
    output logic [15:0]           frame_count
`endif
);
    localparam int PW = $clog2(CLK_DIV) + 1;
    localparam int BW = $clog2(DATA_WIDTH);
    localparam int GW = $clog2(FRAME_GAP + 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_FIRST  = BW'(DATA_WIDTH - 1);
    localparam logic [GW-1:0] GAP_FIRST  = GW'(FRAME_GAP - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} stateT;

    stateT                 state;
    logic [DATA_WIDTH-1:0] shiftReg;
    logic [PW-1:0]         phaseCnt;
    logic [BW-1:0]         bitCnt;
    logic [GW-1:0]         gapCnt;

    always_ff @(posedge max10Board_50MhzClock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            shiftReg     <= '0;
            phaseCnt     <= '0;
            bitCnt       <= '0;
            gapCnt       <= '0;
            sample_ready <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            dac_cs_n     <= 1'b1;
            dac_sclk     <= 1'b0;
            dac_mosi     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sample_ready && sample_valid) begin
                        state        <= SHIFT;
                        // MSB goes straight to the pin; shiftReg holds the bits still to come.
                        dac_mosi     <= sample_data[DATA_WIDTH-1];
                        shiftReg     <= sample_data << 1;
                        bitCnt       <= BIT_FIRST;
                        phaseCnt     <= '0;
                        sample_ready <= 1'b0;
                        busy         <= 1'b1;
                        dac_cs_n     <= 1'b0;
                        dac_sclk     <= 1'b0;
                    end else begin
                        sample_ready <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (phaseCnt != PHASE_LAST) begin
                        phaseCnt <= phaseCnt + 1'b1;
                    end else begin
                        phaseCnt <= '0;
                        if (!dac_sclk) begin
                            dac_sclk <= 1'b1;
                        end else if (bitCnt == '0) begin
                            state      <= GAP;
                            gapCnt     <= GAP_FIRST;
                            frame_done <= 1'b1;
                            dac_cs_n   <= 1'b1;
                            dac_sclk   <= 1'b0;
                            dac_mosi   <= 1'b0;
                        end else begin
                            // mosi only moves together with the falling sclk edge.
                            dac_sclk <= 1'b0;
                            dac_mosi <= shiftReg[DATA_WIDTH-1];
                            shiftReg <= shiftReg << 1;
                            bitCnt   <= bitCnt - 1'b1;
                        end
                    end
                end
                GAP: begin
                    frame_done <= 1'b0;
                    if (gapCnt == '0) begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        sample_ready <= 1'b1;
                    end else begin
                        gapCnt <= gapCnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MUSICBOX_DAC_TX_STATS_EN
    // Counts on the same edge that raises frame_done, so reset-abandoned frames never count.
    always_ff @(posedge max10Board_50MhzClock or posedge reset) begin
        if (reset)
            frame_count <= '0;
        else if (state == SHIFT && phaseCnt == PHASE_LAST && dac_sclk && bitCnt == '0)
            frame_count <= frame_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_gpio_audio_dac_tx.sv
// Bench for gpio_audio_dac_tx: default instance plus an 8-bit/CLK_DIV=1/FRAME_GAP=1 instance.
module tb_gpio_audio_dac_tx;
    localparam int DWA = 16, CDA = 4, FGA = 2;
    localparam int DWB = 8,  CDB = 1, FGB = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [15:0] dataA;
    logic [7:0]  dataB;
    logic validA, readyA, busyA, doneA, csA, sclkA, mosiA;
    logic validB, readyB, busyB, doneB, csB, sclkB, mosiB;
`ifdef MUSICBOX_DAC_TX_STATS_EN
    logic [15:0] countA, countB;
`endif

    always #5 clk = ~clk;

    gpio_audio_dac_tx #(.DATA_WIDTH(DWA), .CLK_DIV(CDA), .FRAME_GAP(FGA)) uA (
        .max10Board_50MhzClock(clk), .reset(reset),
        .sample_data(dataA), .sample_valid(validA), .sample_ready(readyA),
        .busy(busyA), .frame_done(doneA),
        .dac_cs_n(csA), .dac_sclk(sclkA), .dac_mosi(mosiA)
`ifdef MUSICBOX_DAC_TX_STATS_EN
        , .frame_count(countA)
`endif
    );

    gpio_audio_dac_tx #(.DATA_WIDTH(DWB), .CLK_DIV(CDB), .FRAME_GAP(FGB)) uB (
        .max10Board_50MhzClock(clk), .reset(reset),
        .sample_data(dataB), .sample_valid(validB), .sample_ready(readyB),
        .busy(busyB), .frame_done(doneB),
        .dac_cs_n(csB), .dac_sclk(sclkB), .dac_mosi(mosiB)
`ifdef MUSICBOX_DAC_TX_STATS_EN
        , .frame_count(countB)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {ready, busy, done, cs_n, sclk, mosi} from the cycle age since accept.
    function automatic logic [5:0] expOut(input bit fresh, input int age, input logic [31:0] data,
                                          input int dw, input int cd);
        int fl;
        int k;
        logic s;
        fl = 2 * cd * dw;
        if (fresh) return 6'b000100;
        if (age == 0) return 6'b100100;
        if (age <= fl) begin
            k = age - 1;
            s = ((k % (2 * cd)) >= cd) ? 1'b1 : 1'b0;
            return {1'b0, 1'b1, 1'b0, 1'b0, s, data[dw - 1 - k / (2 * cd)]};
        end
        return {1'b0, 1'b1, (age == fl + 1) ? 1'b1 : 1'b0, 1'b1, 1'b0, 1'b0};
    endfunction

    bit freshA = 1'b1, freshB = 1'b1;
    int ageA = 0, ageB = 0;
    logic [31:0] mDataA = '0, mDataB = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            freshA <= 1'b1;
            ageA   <= 0;
        end else if (freshA) begin
            freshA <= 1'b0;
        end else if (ageA == 0) begin
            if (validA) begin
                mDataA <= {16'h0, dataA};
                ageA   <= 1;
            end
        end else if (ageA >= 2 * CDA * DWA + FGA) begin
            ageA <= 0;
        end else begin
            ageA <= ageA + 1;
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            freshB <= 1'b1;
            ageB   <= 0;
        end else if (freshB) begin
            freshB <= 1'b0;
        end else if (ageB == 0) begin
            if (validB) begin
                mDataB <= {24'h0, dataB};
                ageB   <= 1;
            end
        end else if (ageB >= 2 * CDB * DWB + FGB) begin
            ageB <= 0;
        end else begin
            ageB <= ageB + 1;
        end
    end

    // Frame monitor state, index 0 = uA, 1 = uB.
    int cyc = 0;
    logic [31:0] rxWord[2], lastWord[2];
    int rxEdges[2], lowCnt[2], onesCnt[2];
    int lastEdges[2], lastLow[2], lastOnes[2];
    int lastAccept[2], period[2], acceptCnt[2], doneLat[2], readyLat[2];
    bit waitRdy[2];
    logic prevSclk[2], prevCs[2];

    task automatic monitor(input int i, input logic rdy, input logic vld, input logic dn,
                           input logic cs, input logic sck, input logic mo);
        if (!cs) begin
            lowCnt[i]++;
            if (mo) onesCnt[i]++;
            if (sck && !prevSclk[i]) begin
                rxWord[i] = {rxWord[i][30:0], mo};
                rxEdges[i]++;
            end
        end
        if (cs && !prevCs[i]) begin
            lastWord[i]  = rxWord[i];
            lastEdges[i] = rxEdges[i];
            lastLow[i]   = lowCnt[i];
            lastOnes[i]  = onesCnt[i];
            rxWord[i] = '0; rxEdges[i] = 0; lowCnt[i] = 0; onesCnt[i] = 0;
        end
        if (dn) begin
            doneLat[i] = cyc - lastAccept[i];
            waitRdy[i] = 1'b1;
        end else if (waitRdy[i] && rdy) begin
            readyLat[i] = cyc - lastAccept[i];
            waitRdy[i]  = 1'b0;
        end
        if (vld && rdy) begin
            if (lastAccept[i] >= 0) period[i] = cyc - lastAccept[i];
            lastAccept[i] = cyc;
            acceptCnt[i]++;
        end
        prevSclk[i] = sck;
        prevCs[i]   = cs;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rxWord[i] = '0; lastWord[i] = '0; rxEdges[i] = 0; lowCnt[i] = 0; onesCnt[i] = 0;
            lastEdges[i] = 0; lastLow[i] = 0; lastOnes[i] = 0; lastAccept[i] = -1; period[i] = 0;
            acceptCnt[i] = 0; doneLat[i] = 0; readyLat[i] = 0; waitRdy[i] = 1'b0;
            prevSclk[i] = 1'b0; prevCs[i] = 1'b1;
        end
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                for (int i = 0; i < 2; i++) begin
                    rxWord[i] = '0; rxEdges[i] = 0; lowCnt[i] = 0; onesCnt[i] = 0;
                    waitRdy[i] = 1'b0; prevSclk[i] = 1'b0; prevCs[i] = 1'b1;
                end
            end else begin
                check("A.outs", {readyA, busyA, doneA, csA, sclkA, mosiA},
                      expOut(freshA, ageA, mDataA, DWA, CDA));
                check("B.outs", {readyB, busyB, doneB, csB, sclkB, mosiB},
                      expOut(freshB, ageB, mDataB, DWB, CDB));
                monitor(0, readyA, validA, doneA, csA, sclkA, mosiA);
                monitor(1, readyB, validB, doneB, csB, sclkB, mosiB);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitReadyA(input int maxc);
        int n = 0;
        while (readyA !== 1'b1 && n < maxc) begin
            tick(1);
            n++;
        end
        check("A.readyWait", readyA, 1);
    endtask

    task automatic sendA(input logic [15:0] d);
        waitReadyA(300);
        dataA  = d;
        validA = 1'b1;
        tick(1);
        validA = 1'b0;
    endtask

    initial begin
        int acc;
        validA = 1'b0; validB = 1'b0; dataA = '0; dataB = '0;
        tick(3);
        check("rst.A", {readyA, busyA, doneA, csA, sclkA, mosiA}, 6'b000100);
        check("rst.B", {readyB, busyB, doneB, csB, sclkB, mosiB}, 6'b000100);
        reset = 1'b0;
        #1 check("rel.readyLow", readyA, 0);
        tick(1);
        check("rel.readyHigh", readyA, 1);

        // Frame A5C3 on A; B streams 8'h81 with valid held high.
        dataB = 8'h81; validB = 1'b1;
        sendA(16'hA5C3);
        tick(140);
        validB = 1'b0;
        check("t1.word",   lastWord[0], 32'h0000A5C3);
        check("t1.edges",  lastEdges[0], 16);
        check("t1.low",    lastLow[0], 128);
        check("t1.done",   doneLat[0], 129);
        check("t1.ready",  readyLat[0], 131);
        check("t5.word",   lastWord[1], 32'h00000081);
        check("t5.edges",  lastEdges[1], 8);
        check("t5.low",    lastLow[1], 16);
        check("t5.period", period[1], 18);
        check("t5.done",   doneLat[1], 17);

        // Back-to-back 0000 then FFFF.
        waitReadyA(300);
        dataA = 16'h0000; validA = 1'b1;
        tick(1);
        dataA = 16'hFFFF;
        for (int n = 0; n < 300 && readyA !== 1'b1; n++) tick(1);
        check("t2.word0", lastWord[0], 32'h0);
        check("t2.ones0", lastOnes[0], 0);
        tick(1);
        validA = 1'b0;
        check("t2.period", period[0], 131);
        tick(140);
        check("t2.word1", lastWord[0], 32'h0000FFFF);
        check("t2.ones1", lastOnes[0], 128);

        // Input churn while busy must not disturb the frame.
        sendA(16'h0F0F);
        acc = acceptCnt[0];
        dataA = 16'h1234;
        for (int i = 0; i < 100; i++) begin
            validA = (i % 2 == 0) ? 1'b1 : 1'b0;
            tick(1);
        end
        validA = 1'b0;
        tick(40);
        check("t3.word",    lastWord[0], 32'h00000F0F);
        check("t3.accepts", acceptCnt[0], acc);

        // Reset mid high phase of bit 7.
        sendA(16'h0180);
        tick(69);
        check("t4.pre", {csA, sclkA, mosiA}, 3'b011);
        #1 reset = 1'b1;
        #1 check("t4.rst", {readyA, busyA, doneA, csA, sclkA, mosiA}, 6'b000100);
        tick(2);
        reset = 1'b0;
        sendA(16'h8001);
        tick(140);
        check("t4.word",  lastWord[0], 32'h00008001);
        check("t4.edges", lastEdges[0], 16);

`ifdef MUSICBOX_DAC_TX_STATS_EN
        check("t6.afterReset", countA, 1);
        sendA(16'h1111); tick(140);
        sendA(16'h2222); tick(140);
        check("t6.three", countA, 3);
        force uA.frame_count = 16'hFFFF;
        #1 release uA.frame_count;
        sendA(16'h3333); tick(140);
        check("t6.wrap", countA, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        bad++;
        $display("FAIL timeout: got no finish expected finish before %0t", $time);
        $fatal(1, "bench timeout");
    end
endmodule
